// File: rtl/spi_host_master.sv
// spi_host_master: turns a valid/ready register command into one 16-bit SPI mode-0 frame and returns the data byte.
// Define SPI_HOST_WRVERIFY_EN to follow every write with an automatic readback frame and a compare.
module spi_host_master #(
    parameter int CLK_DIV = 2,
    parameter int GAP_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [5:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_mismatch,
    output logic       busy,
    output logic       sclk,
    output logic       cs_n,
    output logic       mosi,
    input  logic       miso
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
    localparam int CW = 16;
    localparam logic [CW-1:0] DIV_END = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_END = CW'(GAP_CYC - 1);

    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [4:0] half;
    logic [15:0] tx;
    logic [7:0] rx;
    logic [15:0] rb_frame;
    logic accept, div_end, rise, fall, frame_done, reload, verify, rb_start;

    assign cmd_ready = state == IDLE;
    assign busy = ~cmd_ready;
    assign mosi = tx[15];
    assign accept = cmd_valid && cmd_ready;
    assign div_end = cnt == DIV_END;
    // SETUP ends with the first rising edge; even halves are high, the last half stays low
    assign rise = div_end && (state == SETUP || (state == SHIFT && half[0] && half != 5'd31));
    assign fall = div_end && state == SHIFT && !half[0];
    assign frame_done = div_end && state == HOLD;
    assign rb_start = state == GAP && nxt == SETUP;
    assign reload = state == IDLE || state != nxt || (state == SHIFT && div_end);

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = accept ? SETUP : IDLE;
            SETUP:   nxt = div_end ? SHIFT : SETUP;
            SHIFT:   nxt = (div_end && half == 5'd31) ? HOLD : SHIFT;
            HOLD:    nxt = div_end ? GAP : HOLD;
            GAP:     nxt = cnt == GAP_END ? (verify ? SETUP : IDLE) : GAP;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            half      <= '0;
            tx        <= '0;
            rx        <= '0;
            sclk      <= 1'b0;
            cs_n      <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            cnt       <= reload ? '0 : cnt + CW'(1);
            half      <= state != SHIFT ? 5'd0 : half + {4'd0, div_end};
            tx        <= accept ? {cmd_write, 1'b0, cmd_addr, cmd_write ? cmd_wdata : 8'h00}
                       : rb_start ? rb_frame : fall ? {tx[14:0], 1'b0} : tx;
            rx        <= rise ? {rx[6:0], miso} : rx;
            sclk      <= rise ? 1'b1 : fall ? 1'b0 : sclk;
            cs_n      <= !(nxt == SETUP || nxt == SHIFT || nxt == HOLD);
            rsp_valid <= frame_done && !verify;
            rsp_rdata <= (frame_done && !verify) ? rx : rsp_rdata;
        end
    end

`ifdef SPI_HOST_WRVERIFY_EN
    logic [5:0] addr;
    logic [7:0] wdata;
    logic wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            verify       <= 1'b0;
            wr           <= 1'b0;
            addr         <= '0;
            wdata        <= '0;
            rsp_mismatch <= 1'b0;
        end else begin
            verify       <= accept ? cmd_write : rb_start ? 1'b0 : verify;
            wr           <= accept ? cmd_write : wr;
            addr         <= accept ? cmd_addr : addr;
            wdata        <= accept ? cmd_wdata : wdata;
            rsp_mismatch <= (frame_done && !verify) ? (wr && rx != wdata) : rsp_mismatch;
        end
    end

    assign rb_frame = {2'b00, addr, 8'h00};
`else
    assign verify = 1'b0;
    assign rb_frame = 16'h0000;
    assign rsp_mismatch = 1'b0;
`endif
endmodule

// File: tb/tb_spi_host_master.sv
// tb_spi_host_master: directed checks of frame format, latency, back-to-back, CLK_DIV=1 and reset abort,
// against a mode-0 slave model; write-verify expectations apply when SPI_HOST_WRVERIFY_EN is defined.
module tb_spi_host_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic cmd_valid = 1'b0, cmd_write = 1'b0, miso = 1'b0;
    logic [5:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic cmd_ready, rsp_valid, rsp_mismatch, busy, sclk, cs_n, mosi;
    logic [7:0] rsp_rdata;

    logic d1_valid = 1'b0, d1_write = 1'b0, d1_miso = 1'b0;
    logic [5:0] d1_addr = '0;
    logic [7:0] d1_wdata = '0;
    logic d1_ready, d1_rsp_valid, d1_mismatch, d1_busy, d1_sclk, d1_cs_n, d1_mosi;
    logic [7:0] d1_rdata;

    spi_host_master #(.CLK_DIV(2), .GAP_CYC(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_mismatch(rsp_mismatch),
        .busy(busy), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
    );

    spi_host_master #(.CLK_DIV(1), .GAP_CYC(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(d1_valid), .cmd_ready(d1_ready),
        .cmd_write(d1_write), .cmd_addr(d1_addr), .cmd_wdata(d1_wdata),
        .rsp_valid(d1_rsp_valid), .rsp_rdata(d1_rdata), .rsp_mismatch(d1_mismatch),
        .busy(d1_busy), .sclk(d1_sclk), .cs_n(d1_cs_n), .mosi(d1_mosi), .miso(d1_miso)
    );

    int tests = 0;
    int fails = 0;

    // Mode-0 slave: presents its MSB at cs_n fall, shifts on sclk fall, captures mosi on sclk rise
    logic [15:0] s_frame = '0, s_tx = '0, s_rx = '0;
    logic [15:0] frames [0:15];
    int nf = 0, run = 0, last_low = 0, rises = 0, last_rises = 0, stray = 0, nrsp = 0;

    always @(negedge cs_n) begin s_tx = s_frame; miso = s_tx[15]; run = 0; rises = 0; end
    always @(negedge sclk) if (!cs_n) begin s_tx = {s_tx[14:0], 1'b0}; miso = s_tx[15]; end
    always @(posedge sclk) if (!cs_n) begin s_rx = {s_rx[14:0], mosi}; rises++; end else stray++;
    always @(posedge cs_n) begin last_low = run; last_rises = rises; if (nf < 16) frames[nf] = s_rx; nf++; end
    always @(negedge clk) begin if (!cs_n) run++; if (rsp_valid) nrsp++; end

    logic [15:0] d1_tx = '0, d1_rx = '0, d1_frame = '0;
    logic d1_prev = 1'b0;
    int d1_run = 0, d1_low = 0, d1_rises = 0, d1_last_rises = 0, d1_stray = 0, d1_tog = 0;

    always @(negedge d1_cs_n) begin d1_tx = 16'h00C3; d1_miso = d1_tx[15]; d1_run = 0; d1_rises = 0; d1_tog = 0; end
    always @(negedge d1_sclk) if (!d1_cs_n) begin d1_tx = {d1_tx[14:0], 1'b0}; d1_miso = d1_tx[15]; end
    always @(posedge d1_sclk) if (!d1_cs_n) begin d1_rx = {d1_rx[14:0], d1_mosi}; d1_rises++; end else d1_stray++;
    always @(posedge d1_cs_n) begin d1_low = d1_run; d1_last_rises = d1_rises; d1_frame = d1_rx; end
    always @(negedge clk) begin
        if (!d1_cs_n) begin d1_run++; if (d1_sclk != d1_prev) d1_tog++; end
        d1_prev = d1_sclk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns cycles from acceptance edge to rsp_valid; fields are scrambled after acceptance
    task automatic do_cmd(input logic w, input logic [5:0] a, input logic [7:0] d, output int lat);
        int n;
        @(negedge clk);
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 1'b0; cmd_write = ~w; cmd_addr = ~a; cmd_wdata = ~d;
        lat = 1;
        while (!rsp_valid && lat < 1000) begin @(negedge clk); lat++; end
    endtask

    initial begin
        int lat, n0, r0, acc, hi;
        repeat (3) @(negedge clk);
        check("rst_cs_n", cs_n, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_mismatch", rsp_mismatch, 0);
        rst_n = 1'b1;

        s_frame = 16'h773D; n0 = nf; r0 = nrsp;
        do_cmd(1'b1, 6'h0A, 8'h3C, lat);
`ifdef SPI_HOST_WRVERIFY_EN
        check("wr_latency", lat, 139);
        check("wv_mismatch", rsp_mismatch, 1);
        check("wv_readback_mosi", frames[n0+1], 16'h0A00);
`else
        check("wr_latency", lat, 69);
        check("wr_mismatch", rsp_mismatch, 0);
`endif
        check("wr_cs_low_cycles", last_low, 68);
        check("wr_rises", last_rises, 16);
        check("wr_mosi", frames[n0], 16'h8A3C);
        check("wr_rdata", rsp_rdata, 8'h3D);
        check("wr_cs_n_at_rsp", cs_n, 1);
        repeat (4) @(negedge clk);
`ifdef SPI_HOST_WRVERIFY_EN
        check("wv_frames", nf - n0, 2);
`else
        check("wr_frames", nf - n0, 1);
`endif
        check("wr_rsp_count", nrsp - r0, 1);

        s_frame = 16'hFFA5; n0 = nf;
        do_cmd(1'b0, 6'h00, 8'h77, lat);
        check("rd_latency", lat, 69);
        check("rd_rdata", rsp_rdata, 8'hA5);
        check("rd_mosi", frames[n0], 16'h0000);
        check("rd_mismatch", rsp_mismatch, 0);
        repeat (4) @(negedge clk);

        s_frame = 16'h00C6; n0 = nf;
        cmd_write = 1'b0; cmd_addr = 6'h05; cmd_valid = 1'b1;
        check("b2b_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_addr = 6'h06;
        check("b2b_busy", busy, 1);
        lat = 1;
        while (!rsp_valid && lat < 1000) begin @(negedge clk); lat++; end
        check("b2b_latency1", lat, 69);
        acc = -1; hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (acc >= 0) cmd_valid = 1'b0;
            else if (cmd_ready) acc = i;
            if (!cs_n) break;
            hi++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("b2b_accept_gap", acc, 2);
        check("b2b_cs_high", hi, 3);
        lat = 1;
        while (!rsp_valid && lat < 1000) begin @(negedge clk); lat++; end
        check("b2b_latency2", lat, 69);
        check("b2b_rdata", rsp_rdata, 8'hC6);
        check("b2b_mosi1", frames[n0], 16'h0500);
        check("b2b_mosi2", frames[n0+1], 16'h0600);
        repeat (4) @(negedge clk);

        d1_addr = 6'h15; d1_write = 1'b0; d1_valid = 1'b1;
        check("d1_ready", d1_ready, 1);
        @(negedge clk);
        d1_valid = 1'b0; d1_addr = 6'h2A;
        check("d1_busy", d1_busy, 1);
        lat = 1;
        while (!d1_rsp_valid && lat < 1000) begin @(negedge clk); lat++; end
        check("d1_latency", lat, 35);
        check("d1_cs_low_cycles", d1_low, 34);
        check("d1_rises", d1_last_rises, 16);
        check("d1_toggles", d1_tog, 32);
        check("d1_rdata", d1_rdata, 8'hC3);
        check("d1_mosi", d1_frame, 16'h1500);
        check("d1_mismatch", d1_mismatch, 0);
        repeat (4) @(negedge clk);

        s_frame = 16'h1234; r0 = nrsp;
        cmd_write = 1'b1; cmd_addr = 6'h03; cmd_wdata = 8'h55; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_pre_cs_n", cs_n, 0);
        #2 rst_n = 1'b0;
        #1;
        check("abort_cs_n", cs_n, 1);
        check("abort_sclk", sclk, 0);
        check("abort_mosi", mosi, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("abort_ready", cmd_ready, 1);
        check("abort_no_rsp", nrsp - r0, 0);
        check("abort_cs_idle", cs_n, 1);
        check("stray_rises", stray, 0);
        check("d1_stray_rises", d1_stray, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
